// File: rtl/mipi_rx_frame_ctrl_if.sv
// Control, raw-stream and frame-stream signals of the MIPI RX capture sequencer.
// master: software control plus packet handler (stimulus side).
// slave: the sequencer.
interface mipi_rx_frame_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             cap_start;
  logic             cap_stop;
  logic             cap_single;
  logic             raw_vld;
  logic [15:0]      raw_data;
  logic             raw_vsync;
  logic             packet_done;
  logic             invalid_start;
  logic             align_re_find;
  logic             frm_vld;
  logic [15:0]      frm_data;
  logic             frm_sof;
  logic             frm_eof;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             err_flag;

  modport master (
    output cap_start, cap_stop, cap_single, raw_vld, raw_data, raw_vsync, packet_done,
           invalid_start,
    input  align_re_find, frm_vld, frm_data, frm_sof, frm_eof, busy, frame_cnt, err_cnt,
           err_flag
  );

  modport slave (
    input  cap_start, cap_stop, cap_single, raw_vld, raw_data, raw_vsync, packet_done,
           invalid_start,
    output align_re_find, frm_vld, frm_data, frm_sof, frm_eof, busy, frame_cnt, err_cnt,
           err_flag
  );
endinterface

// File: rtl/mipi_rx_frame_ctrl.sv
// Capture sequencer for the 2-lane MIPI RX path: arms/disarms capture, gates the raw word
// stream to whole frames, checks frame geometry and forces aligner re-hunt on stalls/errors.
module mipi_rx_frame_ctrl #(
  parameter int unsigned LINES      = 480,
  parameter int unsigned LINE_WORDS = 640,
  parameter int unsigned WDOG_CYC   = 65535,
  parameter int unsigned RESYNC_CYC = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  sclk,
  input  logic                  s_rst_n,
  mipi_rx_frame_ctrl_if.slave   bus
);

  localparam int unsigned LineW = $clog2(LINES + 1);
  // One spare code so an over-long line can never alias to LINE_WORDS.
  localparam int unsigned WordW = $clog2(LINE_WORDS + 2);
  localparam int unsigned WdogW = $clog2(WDOG_CYC + 1);
  localparam int unsigned RsW   = $clog2(RESYNC_CYC + 1);

  typedef enum logic [2:0] {StIdle, StWaitVs, StCapture, StFlush, StResync} state_e;

  state_e           state_q, state_d;
  logic             vsync_d1_q;
  logic             single_q, single_d;
  logic             stop_pend_q, stop_pend_d;
  logic             sof_pend_q, sof_pend_d;
  logic             err_flag_q, err_flag_d;
  logic [LineW-1:0] line_cnt_q, line_cnt_d;
  logic [WordW-1:0] word_cnt_q, word_cnt_d;
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic [RsW-1:0]   rs_cnt_q, rs_cnt_d;
  logic             frm_vld_q, frm_sof_q;
  logic [15:0]      frm_data_q;
  logic [CNT_W-1:0] frame_cnt_q, err_cnt_q;

  logic             vs_rise, wdog_exp, armed;
  logic [WordW-1:0] words_now;
  logic             fwd, err, count_frame, geo_err, frame_done, activity;

  assign vs_rise  = bus.raw_vsync & ~vsync_d1_q;
  assign armed    = (state_q == StWaitVs) || (state_q == StCapture);
  assign wdog_exp = armed && (wdog_q == WdogW'(WDOG_CYC));
  // Word in the same cycle as packet_done is counted before the length check.
  assign words_now = (bus.raw_vld && (word_cnt_q != '1)) ? word_cnt_q + 1'b1 : word_cnt_q;

  // Next-state, geometry checks and forwarding decision.
  always_comb begin
    state_d     = state_q;
    single_d    = single_q;
    stop_pend_d = stop_pend_q;
    sof_pend_d  = sof_pend_q;
    err_flag_d  = err_flag_q;
    line_cnt_d  = line_cnt_q;
    word_cnt_d  = word_cnt_q;
    rs_cnt_d    = '0;
    fwd         = 1'b0;
    err         = 1'b0;
    count_frame = 1'b0;
    geo_err     = 1'b0;
    frame_done  = 1'b0;

    if (state_q != StIdle && bus.cap_stop) stop_pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (bus.cap_start) begin
          state_d    = StWaitVs;
          single_d   = bus.cap_single;
          err_flag_d = 1'b0;
        end
      end
      StWaitVs: begin
        if (bus.invalid_start || wdog_exp) begin
          err = 1'b1;
        end else if (bus.cap_stop) begin
          state_d = StIdle;
        end else if (vs_rise) begin
          state_d    = StCapture;
          line_cnt_d = '0;
          word_cnt_d = '0;
          sof_pend_d = 1'b1;
        end
      end
      StCapture: begin
        fwd        = bus.raw_vld;
        word_cnt_d = words_now;
        if (bus.packet_done) begin
          if (words_now != WordW'(LINE_WORDS)) begin
            geo_err = 1'b1;
          end else begin
            word_cnt_d = '0;
            line_cnt_d = line_cnt_q + 1'b1;
            frame_done = (line_cnt_q == LineW'(LINES - 1));
          end
        end
        if (vs_rise && !frame_done) geo_err = 1'b1;
        if (geo_err || bus.invalid_start || wdog_exp) err = 1'b1;
        else if (frame_done) state_d = StFlush;
      end
      StFlush: begin
        count_frame = 1'b1;
        state_d = (stop_pend_q || bus.cap_stop || single_q) ? StIdle : StWaitVs;
      end
      StResync: begin
        rs_cnt_d = rs_cnt_q + 1'b1;
        if (rs_cnt_q == RsW'(RESYNC_CYC - 1)) begin
          state_d = (stop_pend_q || bus.cap_stop) ? StIdle : StWaitVs;
        end
      end
      default: state_d = StIdle;
    endcase

    // Any error source wins over frame completion and counts once.
    if (err) begin
      state_d    = StResync;
      err_flag_d = 1'b1;
      fwd        = 1'b0;
    end
    if (fwd) sof_pend_d = 1'b0;
    if (state_d == StIdle) stop_pend_d = 1'b0;
  end

  // Watchdog: counts quiet cycles while armed; any activity or state change restarts it.
  always_comb begin
    activity = bus.raw_vld || bus.packet_done || ((state_q == StWaitVs) && vs_rise);
    if (armed && (state_d == state_q) && !activity) wdog_d = wdog_q + 1'b1;
    else wdog_d = '0;
  end

  // State and datapath registers.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q     <= StIdle;
      vsync_d1_q  <= 1'b0;
      single_q    <= 1'b0;
      stop_pend_q <= 1'b0;
      sof_pend_q  <= 1'b0;
      err_flag_q  <= 1'b0;
      line_cnt_q  <= '0;
      word_cnt_q  <= '0;
      wdog_q      <= '0;
      rs_cnt_q    <= '0;
      frm_vld_q   <= 1'b0;
      frm_sof_q   <= 1'b0;
      frm_data_q  <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      vsync_d1_q  <= bus.raw_vsync;
      single_q    <= single_d;
      stop_pend_q <= stop_pend_d;
      sof_pend_q  <= sof_pend_d;
      err_flag_q  <= err_flag_d;
      line_cnt_q  <= line_cnt_d;
      word_cnt_q  <= word_cnt_d;
      wdog_q      <= wdog_d;
      rs_cnt_q    <= rs_cnt_d;
      frm_vld_q   <= fwd;
      frm_sof_q   <= fwd & sof_pend_q;
      if (fwd) frm_data_q <= bus.raw_data;
      if (count_frame) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (err && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign bus.align_re_find = (state_q == StResync);
  assign bus.busy          = (state_q != StIdle);
  assign bus.frm_eof       = (state_q == StFlush);
  assign bus.frm_vld       = frm_vld_q;
  assign bus.frm_sof       = frm_sof_q;
  assign bus.frm_data      = frm_data_q;
  assign bus.frame_cnt     = frame_cnt_q;
  assign bus.err_cnt       = err_cnt_q;
  assign bus.err_flag      = err_flag_q;

endmodule
